countdown_sequencer: RTL and testbench

- Sequences a 4-bit down-counter datapath: loads a preset, decrements it at a programmable tick rate, and supports pause, stop, restart and optional auto-reload.
- Signals terminal count with a one-cycle DONE pulse.
- Sits between the control logic (buttons or host FSM) and the counter display path.
- Replaces free-running counters where start/stop sequencing is needed.

---
 rtl/countdown_sequencer.sv | 103 ++++++++++
 tb/tb_countdown_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Preset-loaded down-counter sequencer with prescaled ticks, pause/hold,
// stop/restart priority and optional auto-reload on terminal count.
module countdown_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             AUTO,
  input  logic [WIDTH-1:0] PRESET,
  output logic [WIDTH-1:0] OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_out;
  logic [PW-1:0]   r_presc;
  logic            r_done;
  logic            w_tick;

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (STOP) begin
        r_state <= S_IDLE;
        r_out   <= '0;
        r_presc <= '0;
      end else if (START) begin
        r_presc <= '0;
        if (PRESET == '0) begin
          r_out   <= '0;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_out   <= PRESET;
          r_state <= S_RUN;
        end
      end else begin
        case (r_state)
          // Leaving HOLD counts on the same edge so a P-cycle pause costs exactly P cycles.
          S_RUN, S_HOLD: begin
            if (PAUSE) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_RUN;
              if (w_tick) begin
                r_presc <= '0;
                if (r_out == WIDTH'(1)) begin
                  r_out   <= '0;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_out <= r_out - WIDTH'(1);
                end
              end else begin
                r_presc <= r_presc + PW'(1);
              end
            end
          end
          S_DONE: begin
            if (AUTO) begin
              if (PRESET == '0) begin
                r_done <= 1'b1;
              end else begin
                r_out   <= PRESET;
                r_presc <= '0;
                r_state <= S_RUN;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign OUT   = r_out;
  assign DONE  = r_done;
  assign STATE = r_state;
  assign BUSY  = (r_state == S_RUN) || (r_state == S_HOLD);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: two instances (DIV=1, DIV=3) share
// stimulus; expected values are hand-computed per step.
module tb_countdown_sequencer;

  logic       Clk = 1'b0;
  logic       RST;
  logic       START, STOP, PAUSE, AUTO;
  logic [3:0] PRESET;

  logic [3:0] u1_out, u3_out;
  logic       u1_busy, u3_busy, u1_done, u3_done;
  logic [1:0] u1_state, u3_state;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  countdown_sequencer #(.WIDTH(4), .DIV(1)) u1 (
    .Clk(Clk), .RST(RST), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .AUTO(AUTO), .PRESET(PRESET), .OUT(u1_out), .BUSY(u1_busy),
    .DONE(u1_done), .STATE(u1_state)
  );

  countdown_sequencer #(.WIDTH(4), .DIV(3)) u3 (
    .Clk(Clk), .RST(RST), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .AUTO(AUTO), .PRESET(PRESET), .OUT(u3_out), .BUSY(u3_busy),
    .DONE(u3_done), .STATE(u3_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] o, input logic [31:0] st,
                      input logic [31:0] b, input logic [31:0] d);
    chk({tag, ".out"},   32'(u1_out),   o);
    chk({tag, ".state"}, 32'(u1_state), st);
    chk({tag, ".busy"},  32'(u1_busy),  b);
    chk({tag, ".done"},  32'(u1_done),  d);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; AUTO = 1'b0; PRESET = 4'd0;
    #2;
    chk1("reset", 0, 0, 0, 0);
    tick();
    RST = 1'b1;
    tick();
    chk1("post_reset_idle", 0, 0, 0, 0);

    // Basic count, DIV=1, PRESET=5
    PRESET = 4'd5; START = 1'b1;
    tick();
    START = 1'b0;
    chk1("basic_e0", 5, 1, 1, 0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("basic.out",  32'(u1_out),  32'(5 - e));
      chk("basic.done", 32'(u1_done), (e == 5) ? 32'd1 : 32'd0);
    end
    chk1("basic_end", 0, 3, 0, 1);
    tick();
    chk1("basic_after", 0, 3, 0, 0);

    // Prescale and pause on DIV=3 instance, PRESET=2
    PRESET = 4'd2; START = 1'b1;
    tick();
    START = 1'b0;
    chk("presc_e0.out", 32'(u3_out), 2);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("presc.out",   32'(u3_out),   (e <= 2) ? 32'd2 : (e == 10) ? 32'd0 : 32'd1);
      chk("presc.done",  32'(u3_done),  (e == 10) ? 32'd1 : 32'd0);
      chk("presc.state", 32'(u3_state),
          (e == 10) ? 32'd3 : (e >= 4 && e <= 7) ? 32'd2 : 32'd1);
      if (e == 3) PAUSE = 1'b1;
      if (e == 7) PAUSE = 1'b0;
    end

    // Auto-reload, DIV=1, PRESET=3
    AUTO = 1'b1; PRESET = 4'd3; START = 1'b1;
    tick();
    START = 1'b0;
    chk("auto_e0.out", 32'(u1_out), 3);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("auto.out",  32'(u1_out),  32'(3 - (e % 4)));
      chk("auto.done", 32'(u1_done), ((e % 4) == 3) ? 32'd1 : 32'd0);
    end
    AUTO = 1'b0; STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk1("auto_stop", 0, 0, 0, 0);

    // START and STOP together: STOP wins
    PRESET = 4'd6; START = 1'b1; STOP = 1'b1;
    tick();
    START = 1'b0; STOP = 1'b0;
    chk1("start_stop", 0, 0, 0, 0);

    // START on the terminal-tick edge: reload, no DONE
    PRESET = 4'd2; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("term_pre.out", 32'(u1_out), 1);
    PRESET = 4'd7; START = 1'b1;
    tick();
    START = 1'b0;
    chk1("start_on_term", 7, 1, 1, 0);

    // STOP mid-count never pulses DONE
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk1("stop_mid", 0, 0, 0, 0);

    // PRESET=0 START goes straight to DONE
    PRESET = 4'd0; START = 1'b1;
    tick();
    START = 1'b0;
    chk1("preset0", 0, 3, 0, 1);
    tick();
    chk1("preset0_after", 0, 3, 0, 0);

    // AUTO with PRESET=0 re-asserts DONE every cycle
    AUTO = 1'b1;
    tick();
    chk1("auto0_a", 0, 3, 0, 1);
    tick();
    chk1("auto0_b", 0, 3, 0, 1);
    AUTO = 1'b0; STOP = 1'b1;
    tick();
    STOP = 1'b0;

    // Restart mid-count
    PRESET = 4'd9; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    chk("restart_pre.out", 32'(u1_out), 6);
    PRESET = 4'd4; START = 1'b1;
    tick();
    START = 1'b0;
    chk1("restart_e0", 4, 1, 1, 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("restart.out",  32'(u1_out),  32'(4 - e));
      chk("restart.done", 32'(u1_done), (e == 4) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset mid-count with OUT=7
    PRESET = 4'd9; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    chk("async_pre.out", 32'(u1_out), 7);
    #2 RST = 1'b0;
    #1;
    chk1("async_reset", 0, 0, 0, 0);
    tick();
    #3 RST = 1'b1;
    tick();
    chk1("async_release", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
